// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of one AES core.
// Keeps one block in flight, routes each result back to its issuer, and
// sequences the long-key-change handshake.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   reqN_valid/data/ready   : block input from requester N (N = 0, 1)
//   respN_valid/data/err    : result to requester N; err marks a timeout
//   respN_ready             : requester N takes its result
//   core_*                  : AES core strobes, data and key-change handshake
//   busy                    : FSM is not idle
module aes_req_arbiter #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_data,
    output logic              resp0_err,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_data,
    output logic              resp1_err,
    input  logic              resp1_ready,
    input  logic              core_ready,
    output logic              core_data_in_stb,
    output logic [DATA_W-1:0] core_data_in,
    input  logic [DATA_W-1:0] core_data_out,
    input  logic              core_data_valid,
    output logic              core_data_out_stb,
    input  logic              core_key_valid,
    input  logic              core_key_change_rq,
    output logic              core_key_ch,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RES,
        S_DELIVER,
        S_KEY_ACK,
        S_KEY_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;
    logic              tag_q, tag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              ostb_q, ostb_d;

    logic can_grant;
    logic gnt_sel;
    logic tag_ready;

    // A grant needs an idle FSM, no pending key change, a keyed and
    // ready core, and at least one requester.
    assign can_grant = (state_q == S_IDLE) & ~core_key_change_rq &
                       core_key_valid & core_ready &
                       (req0_valid | req1_valid);
    assign gnt_sel   = (req0_valid & req1_valid) ? prio_q : req1_valid;
    assign tag_ready = tag_q ? resp1_ready : resp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            tag_q   <= 1'b0;
            cnt_q   <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
            din_q   <= '0;
            ostb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            din_q   <= din_d;
            ostb_q  <= ostb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        din_d   = din_q;
        ostb_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (core_key_change_rq) begin
                    state_d = S_KEY_ACK;
                end else if (can_grant) begin
                    tag_d   = gnt_sel;
                    din_d   = gnt_sel ? req1_data : req0_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (core_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result arriving on the final count still wins.
                if (core_data_valid) begin
                    resp_d  = core_data_out;
                    err_d   = 1'b0;
                    ostb_d  = 1'b1;
                    state_d = S_DELIVER;
                end else if (cnt_q == CNT_MAX) begin
                    resp_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (tag_ready) begin
                    prio_d  = ~tag_q;
                    state_d = S_IDLE;
                end
            end
            S_KEY_ACK: begin
                state_d = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                if (core_key_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req0_ready        = 1'b0;
        req1_ready        = 1'b0;
        resp0_valid       = 1'b0;
        resp1_valid       = 1'b0;
        resp0_data        = '0;
        resp1_data        = '0;
        resp0_err         = 1'b0;
        resp1_err         = 1'b0;
        core_data_in_stb  = 1'b0;
        core_key_ch       = 1'b0;
        core_data_out_stb = ostb_q;
        core_data_in      = din_q;
        busy              = (state_q != S_IDLE);
        // Ready is suppressed under reset so no transfer appears to happen
        // while the state cannot advance.
        req0_ready = can_grant & ~reset & ~gnt_sel;
        req1_ready = can_grant & ~reset & gnt_sel;
        unique case (state_q)
            S_ISSUE: begin
                core_data_in_stb = 1'b1;
            end
            S_DELIVER: begin
                resp0_valid = ~tag_q;
                resp1_valid = tag_q;
                resp0_data  = tag_q ? '0 : resp_q;
                resp1_data  = tag_q ? resp_q : '0;
                resp0_err   = ~tag_q & err_q;
                resp1_err   = tag_q & err_q;
            end
            S_KEY_ACK: begin
                core_key_ch = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter: a vector table for a single
// transaction, directed corner sequences, and a randomized scoreboard run.
module tb_aes_req_arbiter;

    localparam int DW = 128;
    localparam int TO = 16;

    localparam logic [DW-1:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [DW-1:0] D0   = 128'h0123456789abcdef0011223344556677;
    localparam logic [DW-1:0] D1   = 128'hfedcba98765432108899aabbccddeeff;
    localparam logic [DW-1:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          resp0_valid, resp1_valid;
    logic [DW-1:0] resp0_data, resp1_data;
    logic          resp0_err, resp1_err;
    logic          resp0_ready, resp1_ready;
    logic          core_ready;
    logic          core_data_in_stb;
    logic [DW-1:0] core_data_in;
    logic [DW-1:0] core_data_out;
    logic          core_data_valid;
    logic          core_data_out_stb;
    logic          core_key_valid;
    logic          core_key_change_rq;
    logic          core_key_ch;
    logic          busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    aes_req_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .resp0_err(resp0_err), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .resp1_err(resp1_err), .resp1_ready(resp1_ready),
        .core_ready(core_ready), .core_data_in_stb(core_data_in_stb),
        .core_data_in(core_data_in), .core_data_out(core_data_out),
        .core_data_valid(core_data_valid),
        .core_data_out_stb(core_data_out_stb),
        .core_key_valid(core_key_valid),
        .core_key_change_rq(core_key_change_rq),
        .core_key_ch(core_key_ch), .busy(busy)
    );

    // Stand-in for the AES transform used by the scoreboard core model.
    function automatic logic [DW-1:0] fcore(input logic [DW-1:0] x);
        return {x[63:0], x[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_data = '0; req1_data = '0;
        resp0_ready = 0; resp1_ready = 0;
        core_ready = 0; core_data_out = JUNK; core_data_valid = 0;
        core_key_valid = 1; core_key_change_rq = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic check_zero(input string nm);
        chk1({nm, "_rdy0"}, req0_ready, 0);
        chk1({nm, "_rdy1"}, req1_ready, 0);
        chk1({nm, "_rv0"}, resp0_valid, 0);
        chk1({nm, "_rv1"}, resp1_valid, 0);
        chk1({nm, "_err0"}, resp0_err, 0);
        chk1({nm, "_err1"}, resp1_err, 0);
        chkd({nm, "_rd0"}, resp0_data, '0);
        chkd({nm, "_rd1"}, resp1_data, '0);
        chk1({nm, "_stb"}, core_data_in_stb, 0);
        chkd({nm, "_din"}, core_data_in, '0);
        chk1({nm, "_ostb"}, core_data_out_stb, 0);
        chk1({nm, "_kch"}, core_key_ch, 0);
        chk1({nm, "_busy"}, busy, 0);
    endtask

    typedef struct packed {
        logic v0, cr, dv, r0;
        logic rdy0, stb, rv0, ostb, bsy;
    } vec_t;

    vec_t tbl[7];

    // Scoreboard / core-model state
    bit            inflight, itag, have_res, last, prev_dv, clr0, clr1;
    logic [DW-1:0] idata;
    bit            cm_busy;
    int            cm_cnt;
    logic [DW-1:0] cm_data;
    logic [1:0]    exp_g;
    int            ng, nr;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1;
        idle_inputs();
        do_reset();
        #1;
        check_zero("reset");

        // ---- table: single request on requester 0 ----
        tbl[0] = 9'b1100_10000;
        tbl[1] = 9'b0100_01001;
        tbl[2] = 9'b0100_00001;
        tbl[3] = 9'b0110_00001;
        tbl[4] = 9'b0100_00111;
        tbl[5] = 9'b0101_00101;
        tbl[6] = 9'b0100_00000;
        req0_data = PT;
        tick();
        for (int i = 0; i < 7; i++) begin
            req0_valid      = tbl[i].v0;
            core_ready      = tbl[i].cr;
            core_data_valid = tbl[i].dv;
            core_data_out   = tbl[i].dv ? CT : JUNK;
            resp0_ready     = tbl[i].r0;
            #1;
            chk1($sformatf("tbl%0d_rdy0", i), req0_ready, tbl[i].rdy0);
            chk1($sformatf("tbl%0d_rdy1", i), req1_ready, 0);
            chk1($sformatf("tbl%0d_stb", i), core_data_in_stb, tbl[i].stb);
            chk1($sformatf("tbl%0d_rv0", i), resp0_valid, tbl[i].rv0);
            chk1($sformatf("tbl%0d_rv1", i), resp1_valid, 0);
            chk1($sformatf("tbl%0d_ostb", i), core_data_out_stb, tbl[i].ostb);
            chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chkd($sformatf("tbl%0d_rd0", i), resp0_data, tbl[i].rv0 ? CT : '0);
            chk1($sformatf("tbl%0d_err0", i), resp0_err, 0);
            if (tbl[i].stb) chkd($sformatf("tbl%0d_din", i), core_data_in, PT);
            tick();
        end

        // ---- alternation: both valid for 4 blocks ----
        do_reset();
        req0_valid = 1; req0_data = D0;
        req1_valid = 1; req1_data = D1;
        core_ready = 1; resp0_ready = 1; resp1_ready = 1;
        cm_busy = 0; ng = 0; nr = 0;
        for (int c = 0; c < 80 && nr < 4; c++) begin
            core_data_valid = cm_busy && cm_cnt == 0;
            core_data_out   = core_data_valid ? fcore(cm_data) : JUNK;
            #1;
            if (req0_ready || req1_ready) begin
                if (ng < 4) begin
                    chk1($sformatf("alt_g%0d_r1", ng), req1_ready, ng[0]);
                    chk1($sformatf("alt_g%0d_r0", ng), req0_ready, ~ng[0]);
                end
                ng++;
            end
            if (resp0_valid) begin
                chkd("alt_resp0", resp0_data, fcore(D0));
                nr++;
            end
            if (resp1_valid) begin
                chkd("alt_resp1", resp1_data, fcore(D1));
                nr++;
            end
            if (core_data_in_stb && core_ready) begin
                cm_busy = 1; cm_cnt = 1; cm_data = core_data_in;
            end else if (cm_busy) begin
                if (core_data_valid) cm_busy = 0;
                else cm_cnt--;
            end
            tick();
        end
        chkd("alt_nresp", DW'(nr), DW'(4));

        // ---- back-pressure in ISSUE and DELIVER ----
        do_reset();
        req0_valid = 1; req0_data = PT; core_ready = 1;
        #1;
        chk1("bp_grant", req0_ready, 1);
        tick();
        req0_valid = 0; core_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1($sformatf("bp_stb%0d", i), core_data_in_stb, 1);
            chkd($sformatf("bp_din%0d", i), core_data_in, PT);
            tick();
        end
        core_ready = 1;
        #1;
        chk1("bp_stb_last", core_data_in_stb, 1);
        tick();
        #1;
        chk1("bp_stb_drop", core_data_in_stb, 0);
        core_data_valid = 1; core_data_out = CT;
        tick();
        core_data_valid = 0; core_data_out = JUNK;
        req0_valid = 1; req1_valid = 1; req1_data = D1; resp0_ready = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1($sformatf("bp_rv0_%0d", i), resp0_valid, 1);
            chkd($sformatf("bp_rd0_%0d", i), resp0_data, CT);
            chk1($sformatf("bp_ng0_%0d", i), req0_ready, 0);
            chk1($sformatf("bp_ng1_%0d", i), req1_ready, 0);
            tick();
        end
        resp0_ready = 1;
        #1;
        chk1("bp_rv0_end", resp0_valid, 1);
        tick();
        #1;
        chk1("bp_next_r1", req1_ready, 1);
        chk1("bp_next_r0", req0_ready, 0);
        chk1("bp_next_rv0", resp0_valid, 0);
        tick();

        // ---- key change ----
        do_reset();
        req0_valid = 1; req0_data = PT; req1_valid = 1; req1_data = D1;
        core_ready = 1; core_key_change_rq = 1;
        #1;
        chk1("key_nog0", req0_ready, 0);
        chk1("key_nog1", req1_ready, 0);
        chk1("key_kch0", core_key_ch, 0);
        tick();
        core_key_change_rq = 0; core_key_valid = 0;
        #1;
        chk1("key_kch1", core_key_ch, 1);
        chk1("key_busy1", busy, 1);
        chk1("key_nog_ack", req0_ready | req1_ready, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk1($sformatf("key_w%0d_kch", i), core_key_ch, 0);
            chk1($sformatf("key_w%0d_busy", i), busy, 1);
            chk1($sformatf("key_w%0d_nog", i), req0_ready | req1_ready, 0);
            tick();
        end
        core_key_valid = 1;
        #1;
        chk1("key_last_wait", busy, 1);
        chk1("key_last_nog", req0_ready, 0);
        tick();
        #1;
        chk1("key_resume_busy", busy, 0);
        chk1("key_resume_r0", req0_ready, 1);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        core_key_change_rq = 1;
        #1;
        chk1("key_def_wait", core_key_ch, 0);
        chk1("key_def_busy", busy, 1);
        tick();
        core_data_valid = 1; core_data_out = CT;
        #1;
        chk1("key_def_wait2", core_key_ch, 0);
        tick();
        core_data_valid = 0; core_data_out = JUNK; resp0_ready = 0;
        #1;
        chk1("key_def_rv0", resp0_valid, 1);
        chk1("key_def_dlv", core_key_ch, 0);
        tick();
        resp0_ready = 1;
        #1;
        chk1("key_def_dlv2", core_key_ch, 0);
        tick();
        #1;
        chk1("key_def_idle", busy, 0);
        chk1("key_def_idle_kch", core_key_ch, 0);
        tick();
        #1;
        chk1("key_def_ack", core_key_ch, 1);
        tick();
        core_key_change_rq = 0;
        tick();

        // ---- timeout, then coincident valid at the final count ----
        do_reset();
        req1_valid = 1; req1_data = D1; core_ready = 1;
        #1;
        chk1("to_grant1", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick();
        for (int i = 0; i < TO; i++) begin
            #1;
            chk1($sformatf("to_w%0d_rv1", i), resp1_valid, 0);
            chk1($sformatf("to_w%0d_ostb", i), core_data_out_stb, 0);
            tick();
        end
        #1;
        chk1("to_rv1", resp1_valid, 1);
        chk1("to_err1", resp1_err, 1);
        chkd("to_rd1", resp1_data, '0);
        chk1("to_ostb", core_data_out_stb, 0);
        resp1_ready = 1;
        tick();
        #1;
        chk1("to_idle", busy, 0);
        resp1_ready = 0;
        req0_valid = 1; req0_data = PT;
        #1;
        chk1("co_grant0", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        core_data_valid = 1; core_data_out = CT;
        tick();
        core_data_valid = 0; core_data_out = JUNK;
        #1;
        chk1("co_rv0", resp0_valid, 1);
        chk1("co_err0", resp0_err, 0);
        chkd("co_rd0", resp0_data, CT);
        chk1("co_ostb", core_data_out_stb, 1);
        resp0_ready = 1;
        tick();

        // ---- reset in WAIT_RES and in DELIVER ----
        do_reset();
        req0_valid = 1; req0_data = PT; core_ready = 1;
        resp0_ready = 1; resp1_ready = 1;
        tick();
        req0_valid = 0;
        tick();
        tick();
        core_data_valid = 1; core_data_out = CT;
        tick();
        core_data_valid = 0; core_data_out = JUNK;
        tick();
        req1_valid = 1; req1_data = D1;
        #1;
        chk1("rst_pre_g1", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        #1;
        check_zero("rst_wait");
        req0_valid = 1; req1_valid = 1;
        #1;
        chk1("rst_wait_g0", req0_ready, 1);
        chk1("rst_wait_g1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        tick();
        core_data_valid = 1; core_data_out = CT;
        tick();
        core_data_valid = 0; core_data_out = JUNK; resp0_ready = 0;
        #1;
        chk1("rst_dlv_pre", resp0_valid, 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check_zero("rst_dlv");
        req0_valid = 1; req1_valid = 1;
        #1;
        chk1("rst_dlv_g0", req0_ready, 1);
        tick();

        // ---- randomized run against transaction-level scoreboard ----
        do_reset();
        inflight = 0; have_res = 0; last = 1; prev_dv = 0;
        cm_busy = 0; cm_cnt = 0; clr0 = 0; clr1 = 0;
        for (int c = 0; c < 600; c++) begin
            if (!req0_valid && $urandom_range(0, 9) < 4) begin
                req0_valid = 1;
                req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (!req1_valid && $urandom_range(0, 9) < 4) begin
                req1_valid = 1;
                req1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            core_ready  = ($urandom_range(0, 9) < 7);
            resp0_ready = 1'($urandom_range(0, 1));
            resp1_ready = 1'($urandom_range(0, 1));
            core_data_valid = cm_busy && cm_cnt == 0;
            core_data_out = core_data_valid ? fcore(cm_data)
                          : {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            exp_g = 2'b00;
            if (!inflight && core_ready && (req0_valid || req1_valid)) begin
                if (req0_valid && req1_valid) exp_g = last ? 2'b01 : 2'b10;
                else exp_g = req1_valid ? 2'b10 : 2'b01;
            end
            chkd($sformatf("rnd%0d_grant", c),
                 DW'({req1_ready, req0_ready}), DW'(exp_g));
            chk1($sformatf("rnd%0d_ostb", c), core_data_out_stb, prev_dv);
            chkd($sformatf("rnd%0d_rv", c), DW'({resp1_valid, resp0_valid}),
                 DW'(have_res ? (itag ? 2'b10 : 2'b01) : 2'b00));
            if (have_res) begin
                chkd($sformatf("rnd%0d_rd", c),
                     itag ? resp1_data : resp0_data, fcore(idata));
                chk1($sformatf("rnd%0d_err", c),
                     itag ? resp1_err : resp0_err, 0);
            end
            if (core_data_in_stb)
                chkd($sformatf("rnd%0d_din", c), core_data_in, idata);
            if (have_res && (itag ? resp1_ready : resp0_ready)) begin
                inflight = 0; have_res = 0; last = itag;
            end
            if (req0_ready && req0_valid) begin
                inflight = 1; itag = 0; idata = req0_data; clr0 = 1;
            end
            if (req1_ready && req1_valid) begin
                inflight = 1; itag = 1; idata = req1_data; clr1 = 1;
            end
            if (core_data_in_stb && core_ready) begin
                cm_busy = 1; cm_cnt = $urandom_range(0, 4);
                cm_data = core_data_in;
            end else if (cm_busy) begin
                if (core_data_valid) begin
                    cm_busy = 0;
                    have_res = inflight;
                end else begin
                    cm_cnt--;
                end
            end
            prev_dv = core_data_valid;
            tick();
            if (clr0) begin req0_valid = 0; clr0 = 0; end
            if (clr1) begin req1_valid = 0; clr1 = 0; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
